// File: rtl/peripheral_wb_burst_master.sv
// Wishbone B3 burst master: converts a command stream into classic or incrementing/wrapping
// burst cycles, streams write/read beats through side ports and reports completion status.
//
// state  | meaning
// IDLE   | ready for a command, bus released
// WFETCH | waiting for the next write beat from wdat, stb low
// BUS    | beat presented, waiting for ack/err/rty or watchdog expiry
// DONE   | one-cycle completion pulse, no command accepted
module peripheral_wb_burst_master #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int LW      = 5,
    parameter int TIMEOUT = 255
) (
    input  logic            wb_clk,
    input  logic            wb_rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [LW-1:0]   cmd_len,
    input  logic [1:0]      cmd_bte,
    input  logic [DW/8-1:0] cmd_sel,
    input  logic            wdat_valid,
    output logic            wdat_ready,
    input  logic [DW-1:0]   wdat,
    output logic            rdat_valid,
    output logic [DW-1:0]   rdat,
    output logic            done,
    output logic            done_err,
    output logic [AW-1:0]   wb_adr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic            wb_we_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic [2:0]      wb_cti_o,
    output logic [1:0]      wb_bte_o,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic            wb_ack_i,
    input  logic            wb_err_i,
    input  logic            wb_rty_i
);

    localparam int SW = DW / 8;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] WD_LOAD = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WFETCH = 2'd1,
        BUS    = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state;
    logic [LW-1:0] beat;
    logic [LW-1:0] last_beat;
    logic [TW-1:0] wd_cnt;

    logic [LW-1:0] cmd_last;
    logic [LW-1:0] next_beat;
    logic          is_last;
    logic          wd_expired;
    logic          term_err;

    // Wrapping bursts only increment the low address bits inside the N*S byte block.
    function automatic logic [AW-1:0] next_adr(input logic [AW-1:0] a, input logic [1:0] bte);
        logic [AW-1:0] mask;
        case (bte)
            2'b01:   mask = AW'(4 * SW - 1);
            2'b10:   mask = AW'(8 * SW - 1);
            2'b11:   mask = AW'(16 * SW - 1);
            default: mask = '1;
        endcase
        return (a & ~mask) | ((a + AW'(SW)) & mask);
    endfunction

    function automatic logic [2:0] beat_cti(input logic [LW-1:0] idx, input logic [LW-1:0] last);
        if (last == '0)
            return 3'b000;
        else if (idx == last)
            return 3'b111;
        else
            return 3'b010;
    endfunction

    always_comb begin
        cmd_last   = (cmd_len == '0) ? '0 : cmd_len - 1'b1;
        next_beat  = beat + 1'b1;
        is_last    = (beat == last_beat);
        wd_expired = (TIMEOUT > 0) && (state == BUS) && (wd_cnt == '0) && !wb_ack_i;
        term_err   = (state == BUS) && (wb_err_i || wb_rty_i || wd_expired);
        cmd_ready  = wb_rst && (state == IDLE);
        // The next write beat is requested in the same cycle as the ack so bursts stay gapless.
        wdat_ready = wb_rst && ((state == WFETCH) ||
                     ((state == BUS) && wb_we_o && wb_ack_i && !term_err && !is_last));
    end

    always_ff @(posedge wb_clk) begin
        if (!wb_rst) begin
            state      <= IDLE;
            beat       <= '0;
            last_beat  <= '0;
            wd_cnt     <= '0;
            rdat_valid <= 1'b0;
            rdat       <= '0;
            done       <= 1'b0;
            done_err   <= 1'b0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            wb_sel_o   <= '0;
            wb_we_o    <= 1'b0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_cti_o   <= 3'b000;
            wb_bte_o   <= 2'b00;
        end else begin
            rdat_valid <= 1'b0;
            done       <= 1'b0;
            done_err   <= 1'b0;

            if ((state == BUS) && !wb_ack_i && !term_err)
                wd_cnt <= wd_cnt - 1'b1;
            else
                wd_cnt <= WD_LOAD;

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        wb_adr_o  <= cmd_adr;
                        wb_sel_o  <= cmd_sel;
                        wb_we_o   <= cmd_we;
                        wb_bte_o  <= cmd_bte;
                        wb_cti_o  <= beat_cti('0, cmd_last);
                        beat      <= '0;
                        last_beat <= cmd_last;
                        if (cmd_we) begin
                            state <= WFETCH;
                        end else begin
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            state    <= BUS;
                        end
                    end
                end

                WFETCH: begin
                    if (wdat_valid) begin
                        wb_dat_o <= wdat;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        state    <= BUS;
                    end
                end

                BUS: begin
                    if (term_err) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_cti_o <= 3'b000;
                        done     <= 1'b1;
                        done_err <= 1'b1;
                        state    <= DONE;
                    end else if (wb_ack_i) begin
                        if (!wb_we_o) begin
                            rdat       <= wb_dat_i;
                            rdat_valid <= 1'b1;
                        end
                        beat <= next_beat;
                        if (is_last) begin
                            wb_cyc_o <= 1'b0;
                            wb_stb_o <= 1'b0;
                            wb_cti_o <= 3'b000;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            wb_adr_o <= next_adr(wb_adr_o, wb_bte_o);
                            wb_cti_o <= beat_cti(next_beat, last_beat);
                            if (wb_we_o) begin
                                if (wdat_valid) begin
                                    wb_dat_o <= wdat;
                                end else begin
                                    wb_stb_o <= 1'b0;
                                    state    <= WFETCH;
                                end
                            end
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_wb_burst_master.sv
// Bench for peripheral_wb_burst_master: behavioural slave and write-data source on the
// falling edge, expected beats/read data/status held in queues and checked as they appear.
module tb_peripheral_wb_burst_master;

    logic        wb_clk = 1'b0;
    logic        wb_rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr;
    logic [4:0]  cmd_len;
    logic [1:0]  cmd_bte;
    logic [3:0]  cmd_sel;
    logic        wdat_valid, wdat_ready;
    logic [31:0] wdat;
    logic        rdat_valid;
    logic [31:0] rdat;
    logic        done, done_err;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic        wb_ack_i, wb_err_i, wb_rty_i;

    peripheral_wb_burst_master #(.DW(32), .AW(32), .LW(5), .TIMEOUT(8)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_adr(cmd_adr),
        .cmd_len(cmd_len), .cmd_bte(cmd_bte), .cmd_sel(cmd_sel),
        .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat),
        .rdat_valid(rdat_valid), .rdat(rdat), .done(done), .done_err(done_err),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
    );

    always #5 wb_clk = ~wb_clk;

    typedef struct {
        logic [31:0] adr;
        logic [2:0]  cti;
        logic [1:0]  bte;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] dat;
    } beat_t;

    beat_t       bq[$];
    logic [31:0] rq[$];
    logic        dq[$];
    logic [31:0] wq[$];

    int n_chk = 0;
    int n_pass = 0;

    // test-process knobs
    int          wait_states = 0;
    int          err_beat = -1;
    logic        never_ack = 1'b0;
    int          starve_after = -1;
    int          starve_len = 0;
    logic        gap_adr_en = 1'b0;
    logic [31:0] gap_adr = '0;

    // bfm-process counters
    int done_cnt = 0, cyc_cycles = 0, gap_cycles = 0, extra_cnt = 0;
    int ws_cnt = 0, slv_beat = 0, wpop = 0, starve_rem = 0;

    int snap_done, snap_cyc, snap_gap, snap_extra;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] rd_pat(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : (32'hC0DE0000 | a);
    endfunction

    function automatic logic [31:0] exp_adr(input logic [31:0] start, input logic [1:0] bte, input int i);
        logic [31:0] blk, base;
        case (bte)
            2'b01:   blk = 32'd16;
            2'b10:   blk = 32'd32;
            2'b11:   blk = 32'd64;
            default: blk = 32'd0;
        endcase
        if (blk == 0)
            return start + 32'(4 * i);
        base = start - (start % blk);
        return base + ((start - base + 32'(4 * i)) % blk);
    endfunction

    function automatic logic [2:0] exp_cti(input int i, input int n);
        if (n <= 1)
            return 3'b000;
        return (i == n - 1) ? 3'b111 : 3'b010;
    endfunction

    // falling-edge bfm: monitors, slave, write source
    initial begin
        beat_t e;
        wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0; wb_dat_i = '0;
        wdat_valid = 0; wdat = '0;
        forever begin
            @(negedge wb_clk);
            if (rdat_valid) begin
                if (rq.size() == 0) extra_cnt++;
                else check_eq("rdat", rdat, rq.pop_front());
            end
            if (done) begin
                done_cnt++;
                if (dq.size() == 0) extra_cnt++;
                else check_eq("done_err", done_err, dq.pop_front());
            end
            if (wb_cyc_o) cyc_cycles++;
            if (wb_cyc_o && !wb_stb_o) begin
                gap_cycles++;
                if (gap_adr_en) check_eq("gap_adr", wb_adr_o, gap_adr);
            end

            wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0;
            if (!wb_cyc_o) slv_beat = 0;
            if (!(wb_cyc_o && wb_stb_o)) ws_cnt = 0;
            if (wb_cyc_o && wb_stb_o && !never_ack) begin
                if (ws_cnt < wait_states) begin
                    ws_cnt++;
                end else begin
                    ws_cnt = 0;
                    if (bq.size() == 0) begin
                        extra_cnt++;
                    end else begin
                        e = bq.pop_front();
                        check_eq("beat_adr", wb_adr_o, e.adr);
                        check_eq("beat_cti", wb_cti_o, e.cti);
                        check_eq("beat_bte", wb_bte_o, e.bte);
                        check_eq("beat_sel", wb_sel_o, e.sel);
                        check_eq("beat_we", wb_we_o, e.we);
                        if (e.we) check_eq("beat_wdat", wb_dat_o, e.dat);
                    end
                    if (!wb_we_o) wb_dat_i = rd_pat(wb_adr_o);
                    if (slv_beat == err_beat) wb_err_i = 1;
                    else wb_ack_i = 1;
                    slv_beat++;
                end
            end

            if (starve_rem > 0) begin
                wdat_valid = 0;
                starve_rem--;
            end else begin
                wdat_valid = (wq.size() > 0);
                if (wdat_valid) wdat = wq[0];
            end
            #1;
            if (cmd_valid && cmd_ready) wpop = 0;
            if (wdat_valid && wdat_ready) begin
                void'(wq.pop_front());
                if (wpop == starve_after) starve_rem = starve_len;
                wpop++;
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] adr, input int len, input logic [1:0] bte,
                         input logic [3:0] sel, input int n_term, input int n_rd,
                         input logic exp_err, input logic exp_done, input logic [31:0] wbase);
        int   n;
        logic accepted;
        beat_t e;
        snap_done = done_cnt; snap_cyc = cyc_cycles; snap_gap = gap_cycles; snap_extra = extra_cnt;
        n = (len == 0) ? 1 : len;
        for (int i = 0; i < n; i++) begin
            e.adr = exp_adr(adr, bte, i);
            e.cti = exp_cti(i, n);
            e.bte = bte;
            e.sel = sel;
            e.we  = we;
            e.dat = wbase + 32'(i);
            if (i < n_term) bq.push_back(e);
            if (!we && i < n_rd) rq.push_back(rd_pat(e.adr));
            if (we) wq.push_back(e.dat);
        end
        if (exp_done) dq.push_back(exp_err);
        @(negedge wb_clk);
        cmd_we = we; cmd_adr = adr; cmd_len = 5'(len); cmd_bte = bte; cmd_sel = sel;
        cmd_valid = 1;
        accepted = 0;
        for (int i = 0; i < 50; i++) begin
            #1 accepted = cmd_ready;
            @(posedge wb_clk);
            if (accepted) break;
            @(negedge wb_clk);
        end
        #1 cmd_valid = 0;
        check_eq("cmd_accept", accepted, 1);
    endtask

    task automatic finish_cmd(input int exp_done, input int exp_cyc, input int exp_gap);
        int lim;
        lim = (exp_done != 0) ? 300 : 20;
        for (int i = 0; i < lim; i++) begin
            @(negedge wb_clk);
            #2;
            if (done_cnt != snap_done) break;
        end
        repeat (3) @(negedge wb_clk);
        #2;
        check_eq("done_count", done_cnt - snap_done, exp_done);
        if (exp_cyc >= 0) check_eq("cyc_cycles", cyc_cycles - snap_cyc, exp_cyc);
        check_eq("gap_cycles", gap_cycles - snap_gap, exp_gap);
        check_eq("extras", extra_cnt - snap_extra, 0);
        check_eq("beats_left", bq.size(), 0);
        check_eq("rdat_left", rq.size(), 0);
        check_eq("done_left", dq.size(), 0);
        check_eq("wdat_left", wq.size(), 0);
        bq.delete(); rq.delete(); dq.delete(); wq.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        wb_rst = 0; cmd_valid = 0; cmd_we = 0; cmd_adr = '0; cmd_len = '0; cmd_bte = '0; cmd_sel = '0;
        repeat (3) @(posedge wb_clk);
        #1;
        check_eq("rst_cyc_stb", {wb_cyc_o, wb_stb_o}, 0);
        check_eq("rst_ready", {cmd_ready, wdat_ready}, 0);
        check_eq("rst_status", {done, done_err, rdat_valid}, 0);
        @(negedge wb_clk) wb_rst = 1;
        @(posedge wb_clk) #1;
        check_eq("idle_cmd_ready", cmd_ready, 1);

        // single read, 2 wait states
        wait_states = 2;
        issue(0, 32'h100, 1, 2'b00, 4'hF, 1, 1, 0, 1, 0);
        finish_cmd(1, 3, 0);

        // linear write burst, zero wait
        wait_states = 0;
        issue(1, 32'h200, 4, 2'b00, 4'hF, 4, 0, 0, 1, 32'h1);
        finish_cmd(1, 4, 0);

        // wrap8 read
        issue(0, 32'h118, 8, 2'b10, 4'hF, 8, 8, 0, 1, 0);
        finish_cmd(1, 8, 0);

        // wrap4 write from 0x0C
        issue(1, 32'h0C, 4, 2'b01, 4'hC, 4, 0, 0, 1, 32'hA0);
        finish_cmd(1, 4, 0);

        // write data starvation after first beat
        starve_after = 0; starve_len = 5; gap_adr = 32'h204; gap_adr_en = 1;
        issue(1, 32'h200, 3, 2'b00, 4'h3, 3, 0, 0, 1, 32'h10);
        finish_cmd(1, -1, 5);
        starve_after = -1; gap_adr_en = 0;

        // error on beat 2 of 4
        err_beat = 1;
        issue(0, 32'h300, 4, 2'b00, 4'hF, 2, 1, 1, 1, 0);
        finish_cmd(1, 2, 0);
        err_beat = -1;

        // next command after error
        issue(0, 32'h100, 1, 2'b00, 4'hF, 1, 1, 0, 1, 0);
        finish_cmd(1, 1, 0);

        // watchdog: slave never acks
        never_ack = 1;
        issue(0, 32'h400, 4, 2'b01, 4'hF, 0, 0, 1, 1, 0);
        finish_cmd(1, 8, 0);
        never_ack = 0;

        // reset during beat 3 of 4
        wait_states = 1;
        issue(0, 32'h500, 4, 2'b00, 4'hF, 2, 2, 0, 0, 0);
        for (int i = 0; i < 100; i++) begin
            @(negedge wb_clk);
            #2;
            if (bq.size() == 0) break;
        end
        @(negedge wb_clk);
        wb_rst = 0;
        @(posedge wb_clk) #1;
        check_eq("mid_rst_bus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o, wb_bte_o, wb_sel_o}, 0);
        check_eq("mid_rst_adr", wb_adr_o, 0);
        check_eq("mid_rst_dat", {wb_dat_o, rdat}, 0);
        check_eq("mid_rst_status", {done, done_err, rdat_valid, cmd_ready, wdat_ready}, 0);
        repeat (2) @(posedge wb_clk);
        @(negedge wb_clk) wb_rst = 1;
        finish_cmd(0, -1, 0);

        // recovery after reset
        wait_states = 0;
        issue(0, 32'h600, 2, 2'b00, 4'hF, 2, 2, 0, 1, 0);
        finish_cmd(1, 2, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
